riscv_imem_arbiter: RTL and testbench

RISCV_IMEM_ARBITER -- requirements
Module: riscv_imem_arbiter

---
 rtl/riscv_imem_arbiter.sv | 116 +++++++++++
 tb/tb_riscv_imem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_imem_arbiter.sv
// Two-port instruction-fetch arbiter onto a single memory port.
// A 1-bit tag FIFO remembers which port each in-flight request came from so responses route back in order.
module riscv_imem_arbiter #(
    parameter int DEPTH   = 4,
    parameter int REQ_SZ  = 67,
    parameter int RESP_SZ = 35
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [REQ_SZ-1:0]        imemreq0_msg,
    input  logic                     imemreq0_val,
    output logic                     imemreq0_rdy,
    output logic [RESP_SZ-1:0]       imemresp0_msg,
    output logic                     imemresp0_val,

    input  logic [REQ_SZ-1:0]        imemreq1_msg,
    input  logic                     imemreq1_val,
    output logic                     imemreq1_rdy,
    output logic [RESP_SZ-1:0]       imemresp1_msg,
    output logic                     imemresp1_val,

    output logic [REQ_SZ-1:0]        memreq_msg,
    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    input  logic [RESP_SZ-1:0]       memresp_msg,
    input  logic                     memresp_val,

    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_orphan
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] tag_q, tag_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_grant_q, last_grant_d;
    logic             err_q, err_d;

    logic full;
    logic empty;
    logic grant1;
    logic fire;
    logic head;
    logic route;
    logic orphan;

    // Full/empty come from the registered count only, so a same-cycle pop never opens a slot for a fire.
    always_comb begin
        full   = (count_q == CNT_W'(DEPTH));
        empty  = (count_q == '0);
        grant1 = imemreq1_val & (~imemreq0_val | ~last_grant_q);

        memreq_val   = reset & (imemreq0_val | imemreq1_val) & ~full;
        memreq_msg   = (grant1 & memreq_val) ? imemreq1_msg : imemreq0_msg;
        imemreq0_rdy = reset & ~grant1 & memreq_rdy & ~full;
        imemreq1_rdy = reset &  grant1 & memreq_rdy & ~full;
        fire         = memreq_val & memreq_rdy;
    end

    // Response path is purely combinational: the FIFO head picks the destination port in the same cycle.
    always_comb begin
        head   = tag_q[rptr_q];
        route  = reset & memresp_val & ~empty;
        orphan = reset & memresp_val &  empty;

        imemresp0_val = route & ~head;
        imemresp1_val = route &  head;
        imemresp0_msg = memresp_msg;
        imemresp1_msg = memresp_msg;
    end

    always_comb begin
        tag_d        = tag_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        last_grant_d = last_grant_q;
        err_d        = err_q | orphan;
        count_d      = count_q + CNT_W'(fire) - CNT_W'(route);

        if (fire) begin
            tag_d[wptr_q] = grant1;
            wptr_d        = wptr_q + PTR_W'(1);
            last_grant_d  = grant1;
        end
        if (route) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    // last_grant resets to 1 so that port 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign outstanding = count_q;
    assign err_orphan  = err_q;

endmodule

// File: tb/tb_riscv_imem_arbiter.sv
// Directed bench for riscv_imem_arbiter: arbitration, in-order routing, full/empty limits, orphans and reset.
module tb_riscv_imem_arbiter;

    logic          clk;
    logic          reset;
    logic [66:0]   imemreq0_msg;
    logic          imemreq0_val;
    logic          imemreq0_rdy;
    logic [34:0]   imemresp0_msg;
    logic          imemresp0_val;
    logic [66:0]   imemreq1_msg;
    logic          imemreq1_val;
    logic          imemreq1_rdy;
    logic [34:0]   imemresp1_msg;
    logic          imemresp1_val;
    logic [66:0]   memreq_msg;
    logic          memreq_val;
    logic          memreq_rdy;
    logic [34:0]   memresp_msg;
    logic          memresp_val;
    logic [2:0]    outstanding;
    logic          err_orphan;

    int checks = 0;
    int errors = 0;

    riscv_imem_arbiter #(.DEPTH(4), .REQ_SZ(67), .RESP_SZ(35)) dut (
        .clk           (clk),
        .reset         (reset),
        .imemreq0_msg  (imemreq0_msg),
        .imemreq0_val  (imemreq0_val),
        .imemreq0_rdy  (imemreq0_rdy),
        .imemresp0_msg (imemresp0_msg),
        .imemresp0_val (imemresp0_val),
        .imemreq1_msg  (imemreq1_msg),
        .imemreq1_val  (imemreq1_val),
        .imemreq1_rdy  (imemreq1_rdy),
        .imemresp1_msg (imemresp1_msg),
        .imemresp1_val (imemresp1_val),
        .memreq_msg    (memreq_msg),
        .memreq_val    (memreq_val),
        .memreq_rdy    (memreq_rdy),
        .memresp_msg   (memresp_msg),
        .memresp_val   (memresp_val),
        .outstanding   (outstanding),
        .err_orphan    (err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [66:0] m0,
                                 input logic v1, input logic [66:0] m1,
                                 input logic rdy, input logic rv, input logic [34:0] rm);
        imemreq0_val = v0;
        imemreq0_msg = m0;
        imemreq1_val = v1;
        imemreq1_msg = m1;
        memreq_rdy   = rdy;
        memresp_val  = rv;
        memresp_msg  = rm;
        #1;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p;

        // Reset held with every input active: nothing may leak out.
        reset = 1'b0;
        imemreq0_val = 1'b1; imemreq0_msg = 67'h11;
        imemreq1_val = 1'b1; imemreq1_msg = 67'h22;
        memreq_rdy   = 1'b1;
        memresp_val  = 1'b1; memresp_msg = 35'h33;
        #2;
        checkOutput("rst_memreq_val", memreq_val, 0);
        checkOutput("rst_rdy0", imemreq0_rdy, 0);
        checkOutput("rst_rdy1", imemreq1_rdy, 0);
        checkOutput("rst_resp0_val", imemresp0_val, 0);
        checkOutput("rst_resp1_val", imemresp1_val, 0);
        checkOutput("rst_outstanding", outstanding, 0);
        checkOutput("rst_err", err_orphan, 0);
        @(posedge clk);
        waitEdge();
        checkOutput("rst_err_held", err_orphan, 0);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitEdge();

        // Round-robin with both ports busy, memory latency 2.
        applyStimulus(1, 67'h101, 1, 67'h201, 1, 0, 0);
        checkOutput("rr_c1_val", memreq_val, 1);
        checkOutput("rr_c1_msg", memreq_msg, 67'h101);
        checkOutput("rr_c1_rdy0", imemreq0_rdy, 1);
        checkOutput("rr_c1_rdy1", imemreq1_rdy, 0);
        waitEdge();
        applyStimulus(1, 67'h102, 1, 67'h202, 1, 0, 0);
        checkOutput("rr_c2_msg", memreq_msg, 67'h202);
        checkOutput("rr_c2_rdy0", imemreq0_rdy, 0);
        checkOutput("rr_c2_rdy1", imemreq1_rdy, 1);
        checkOutput("rr_c2_out", outstanding, 1);
        waitEdge();
        applyStimulus(1, 67'h103, 1, 67'h203, 1, 1, 35'h31);
        checkOutput("rr_c3_msg", memreq_msg, 67'h103);
        checkOutput("rr_c3_resp0_val", imemresp0_val, 1);
        checkOutput("rr_c3_resp1_val", imemresp1_val, 0);
        checkOutput("rr_c3_resp0_msg", imemresp0_msg, 35'h31);
        checkOutput("rr_c3_resp1_msg", imemresp1_msg, 35'h31);
        checkOutput("rr_c3_out", outstanding, 2);
        waitEdge();
        applyStimulus(1, 67'h104, 1, 67'h204, 1, 1, 35'h32);
        checkOutput("rr_c4_msg", memreq_msg, 67'h204);
        checkOutput("rr_c4_resp0_val", imemresp0_val, 0);
        checkOutput("rr_c4_resp1_val", imemresp1_val, 1);
        checkOutput("rr_c4_out", outstanding, 2);
        waitEdge();
        applyStimulus(0, 67'h105, 0, 67'h205, 1, 1, 35'h33);
        checkOutput("rr_c5_val", memreq_val, 0);
        checkOutput("rr_c5_idle_msg", memreq_msg, 67'h105);
        checkOutput("rr_c5_resp0_val", imemresp0_val, 1);
        checkOutput("rr_c5_out", outstanding, 2);
        waitEdge();
        applyStimulus(0, 0, 0, 0, 1, 1, 35'h34);
        checkOutput("rr_c6_resp1_val", imemresp1_val, 1);
        checkOutput("rr_c6_resp0_val", imemresp0_val, 0);
        checkOutput("rr_c6_out", outstanding, 1);
        waitEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rr_end_out", outstanding, 0);
        checkOutput("rr_end_err", err_orphan, 0);

        // Port 1 alone fills the tag FIFO and then gets blocked.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 67'h300 + 67'(i), 1, 0, 0);
            checkOutput("fill1_rdy1", imemreq1_rdy, 1);
            checkOutput("fill1_msg", memreq_msg, 67'h300 + 67'(i));
            checkOutput("fill1_out", outstanding, 67'(i));
            waitEdge();
        end
        applyStimulus(0, 0, 1, 67'h304, 1, 0, 0);
        checkOutput("full_val", memreq_val, 0);
        checkOutput("full_rdy1", imemreq1_rdy, 0);
        checkOutput("full_out", outstanding, 4);
        waitEdge();
        applyStimulus(0, 0, 1, 67'h304, 1, 1, 35'h41);
        checkOutput("full_pop_val", memreq_val, 0);
        checkOutput("full_pop_rdy1", imemreq1_rdy, 0);
        checkOutput("full_pop_resp1", imemresp1_val, 1);
        checkOutput("full_pop_resp0", imemresp0_val, 0);
        waitEdge();
        applyStimulus(0, 0, 1, 67'h304, 1, 0, 0);
        checkOutput("refill_out", outstanding, 3);
        checkOutput("refill_val", memreq_val, 1);
        checkOutput("refill_rdy1", imemreq1_rdy, 1);
        waitEdge();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 35'h50 + 35'(i));
            checkOutput("drain1_resp1", imemresp1_val, 1);
            checkOutput("drain1_resp0", imemresp0_val, 0);
            checkOutput("drain1_out", outstanding, 67'(4 - i));
            waitEdge();
        end

        // Port 0 fills the FIFO; one response at full frees a slot only for the next cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 67'h400 + 67'(i), 0, 0, 1, 0, 0);
            checkOutput("fill0_rdy0", imemreq0_rdy, 1);
            checkOutput("fill0_out", outstanding, 67'(i));
            waitEdge();
        end
        applyStimulus(1, 67'h404, 0, 0, 1, 1, 35'h60);
        checkOutput("full0_resp0", imemresp0_val, 1);
        checkOutput("full0_resp1", imemresp1_val, 0);
        checkOutput("full0_val", memreq_val, 0);
        checkOutput("full0_rdy0", imemreq0_rdy, 0);
        checkOutput("full0_out", outstanding, 4);
        waitEdge();
        applyStimulus(1, 67'h404, 0, 0, 1, 0, 0);
        checkOutput("after_pop_out", outstanding, 3);
        checkOutput("after_pop_val", memreq_val, 1);
        checkOutput("after_pop_rdy0", imemreq0_rdy, 1);
        checkOutput("after_pop_msg", memreq_msg, 67'h404);
        waitEdge();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 35'h70 + 35'(i));
            checkOutput("drain0_resp0", imemresp0_val, 1);
            checkOutput("drain0_resp1", imemresp1_val, 0);
            checkOutput("drain0_msg", imemresp0_msg, 35'h70 + 35'(i));
            checkOutput("drain0_out", outstanding, 67'(4 - i));
            waitEdge();
        end

        // Nine request/response pairs alternating ports, wrapping both pointers.
        for (int i = 0; i < 9; i++) begin
            p = i % 2;
            applyStimulus(p == 0, 67'h500 + 67'(i), p == 1, 67'h600 + 67'(i), 1, 0, 0);
            checkOutput("pair_msg", memreq_msg, (p == 1) ? 67'h600 + 67'(i) : 67'h500 + 67'(i));
            checkOutput("pair_out0", outstanding, 0);
            waitEdge();
            applyStimulus(0, 0, 0, 0, 1, 1, 35'h80 + 35'(i));
            checkOutput("pair_resp0", imemresp0_val, p == 0);
            checkOutput("pair_resp1", imemresp1_val, p == 1);
            checkOutput("pair_out1", outstanding, 1);
            waitEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pairs_out", outstanding, 0);
        checkOutput("pairs_err", err_orphan, 0);

        // Orphan response with nothing outstanding; the flag is sticky.
        applyStimulus(0, 0, 0, 0, 1, 1, 35'h90);
        checkOutput("orph_resp0", imemresp0_val, 0);
        checkOutput("orph_resp1", imemresp1_val, 0);
        checkOutput("orph_err_pre", err_orphan, 0);
        waitEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("orph_err", err_orphan, 1);
        checkOutput("orph_out", outstanding, 0);
        waitEdge();
        applyStimulus(1, 67'h700, 0, 0, 1, 0, 0);
        waitEdge();
        applyStimulus(0, 0, 0, 0, 1, 1, 35'h91);
        checkOutput("orph_next_resp0", imemresp0_val, 1);
        waitEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("orph_sticky", err_orphan, 1);
        checkOutput("orph_sticky_out", outstanding, 0);

        // Asynchronous reset with three requests in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 67'h800 + 67'(i), 0, 0, 1, 0, 0);
            waitEdge();
        end
        applyStimulus(1, 67'h803, 0, 0, 0, 0, 0);
        checkOutput("pre_rst_out", outstanding, 3);
        checkOutput("pre_rst_err", err_orphan, 1);
        #2;
        reset = 1'b0;
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        #1;
        checkOutput("arst_out", outstanding, 0);
        checkOutput("arst_err", err_orphan, 0);
        checkOutput("arst_val", memreq_val, 0);
        checkOutput("arst_rdy0", imemreq0_rdy, 0);
        checkOutput("arst_resp0", imemresp0_val, 0);
        checkOutput("arst_resp1", imemresp1_val, 0);
        waitEdge();
        reset = 1'b1;
        applyStimulus(1, 67'h900, 1, 67'ha00, 0, 1, 35'h99);
        checkOutput("post_rst_val", memreq_val, 1);
        checkOutput("post_rst_msg", memreq_msg, 67'h900);
        checkOutput("post_rst_rdy0", imemreq0_rdy, 0);
        checkOutput("post_rst_resp0", imemresp0_val, 0);
        checkOutput("post_rst_resp1", imemresp1_val, 0);
        checkOutput("post_rst_err_pre", err_orphan, 0);
        waitEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_err", err_orphan, 1);
        checkOutput("post_rst_out", outstanding, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
